// File: rtl/regfile_arbiter.sv
// regfile_arbiter
//   Arbitrates a single shared register-file slot between two write
//   requesters (round-robin between them) and one dual-address read
//   requester. Writes win over the read until the read has lost
//   STARVE_LIMIT consecutive cycles, after which the read is forced through.
//
// Ports
//   i_clk, i_rst                 clock, synchronous active-high reset
//   i_wr0_* / o_wr0_ack          write requester 0 (req/addr/data, ack pulse)
//   i_wr1_* / o_wr1_ack          write requester 1 (req/addr/data, ack pulse)
//   i_rd_req, i_rd_addr1/2       read request and its two addresses
//   o_rd_ack                     read granted this cycle
//   o_rd_valid, o_rd_data1/2     read result, one cycle after o_rd_ack
//   o_rf_raddr1/2, o_rf_waddr,
//   o_rf_wdata, o_rf_we          register file command (combinational)
//   i_rf_rdata1/2                registered read data from the register file
module regfile_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_wr0_req,
  input  logic [4:0]  i_wr0_addr,
  input  logic [31:0] i_wr0_data,
  output logic        o_wr0_ack,
  input  logic        i_wr1_req,
  input  logic [4:0]  i_wr1_addr,
  input  logic [31:0] i_wr1_data,
  output logic        o_wr1_ack,
  input  logic        i_rd_req,
  input  logic [4:0]  i_rd_addr1,
  input  logic [4:0]  i_rd_addr2,
  output logic        o_rd_ack,
  output logic        o_rd_valid,
  output logic [31:0] o_rd_data1,
  output logic [31:0] o_rd_data2,
  output logic [4:0]  o_rf_raddr1,
  output logic [4:0]  o_rf_raddr2,
  output logic [4:0]  o_rf_waddr,
  output logic [31:0] o_rf_wdata,
  output logic        o_rf_we,
  input  logic [31:0] i_rf_rdata1,
  input  logic [31:0] i_rf_rdata2
);

  localparam int            CW      = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT   = CW'(STARVE_LIMIT);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic          rr_ptr;
  logic [CW-1:0] starve_cnt;
  logic          rd_valid_q;

  logic          grant_wr0;
  logic          grant_wr1;
  logic          grant_rd;
  logic          grant_wr;
  logic          force_rd;
  logic [4:0]    win_addr;
  logic [31:0]   win_data;

  assign force_rd = i_rd_req && (starve_cnt == LIMIT);
  assign grant_wr = grant_wr0 || grant_wr1;

  // Grant selection: reset masks everything, a starved read beats writes,
  // contested writes follow rr_ptr, a lone writer always wins.
  always_comb begin
    grant_wr0 = 1'b0;
    grant_wr1 = 1'b0;
    grant_rd  = 1'b0;
    if (i_rst) begin
      grant_rd = 1'b0;
    end else if (force_rd) begin
      grant_rd = 1'b1;
    end else if (i_wr0_req && i_wr1_req) begin
      if (rr_ptr) begin
        grant_wr1 = 1'b1;
      end else begin
        grant_wr0 = 1'b1;
      end
    end else if (i_wr0_req) begin
      grant_wr0 = 1'b1;
    end else if (i_wr1_req) begin
      grant_wr1 = 1'b1;
    end else if (i_rd_req) begin
      grant_rd = 1'b1;
    end else begin
      grant_rd = 1'b0;
    end
  end

  // Write-port mux from the winning requester.
  always_comb begin
    win_addr = 5'd0;
    win_data = 32'd0;
    if (grant_wr1) begin
      win_addr = i_wr1_addr;
      win_data = i_wr1_data;
    end else begin
      win_addr = i_wr0_addr;
      win_data = i_wr0_data;
    end
  end

  assign o_wr0_ack   = grant_wr0;
  assign o_wr1_ack   = grant_wr1;
  assign o_rd_ack    = grant_rd;
  // A write to r0 is acked and consumes the slot but never reaches the file.
  assign o_rf_we     = grant_wr && (win_addr != 5'd0);
  assign o_rf_waddr  = win_addr;
  assign o_rf_wdata  = win_data;
  assign o_rf_raddr1 = i_rd_addr1;
  assign o_rf_raddr2 = i_rd_addr2;
  // Masking with i_rst keeps a read acked just before reset from showing
  // up as valid in the reset cycle itself.
  assign o_rd_valid  = rd_valid_q && !i_rst;
  assign o_rd_data1  = i_rf_rdata1;
  assign o_rd_data2  = i_rf_rdata2;

  // Arbitration state: read-valid pipeline, round-robin pointer, starvation count.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rd_valid_q <= 1'b0;
      rr_ptr     <= 1'b0;
      starve_cnt <= '0;
    end else begin
      rd_valid_q <= grant_rd;
      if (grant_wr0) begin
        rr_ptr <= 1'b1;
      end else if (grant_wr1) begin
        rr_ptr <= 1'b0;
      end else begin
        rr_ptr <= rr_ptr;
      end
      if (!i_rd_req || grant_rd) begin
        starve_cnt <= '0;
      end else if (grant_wr && (starve_cnt != LIMIT)) begin
        starve_cnt <= starve_cnt + CNT_ONE;
      end else begin
        starve_cnt <= starve_cnt;
      end
    end
  end

endmodule
